// File: rtl/decode_pipe.sv
// Single-issue instruction decoder with a one-deep registered output and a valid/ready handshake on both sides.
// Define DECODE_LONG_INSTR_EN to enable the two-word LDS/STS forms, which are decoded across two accepted words.
`ifndef OPCODE_COUNT
`define OPCODE_COUNT 14
`endif
`ifndef GROUP_COUNT
`define GROUP_COUNT 11
`endif

module decode_pipe #(
  parameter int INSTR_WIDTH  = 16,
  parameter int R_ADDR_WIDTH = 5,
  parameter int IMD_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`OPCODE_COUNT-1:0]  opcode_type,
  output logic [`GROUP_COUNT-1:0]   opcode_group,
  output logic [R_ADDR_WIDTH-1:0]   opcode_rd,
  output logic [R_ADDR_WIDTH-1:0]   opcode_rr,
  output logic [IMD_WIDTH-1:0]      opcode_imd,
  output logic [2:0]                opcode_bit,
  output logic [1:0]                out_words
);

  // opcode_type is one-hot; the bit position of each type is its enum value.
  typedef enum logic [3:0] {
    T_NOP, T_UNKNOWN, T_ADD, T_ADC, T_SUB, T_AND, T_EOR, T_OR,
    T_MOV, T_NEG, T_LDI, T_LDS, T_STS, T_LD_Y
  } type_e;

  typedef enum logic {IDLE, WAIT2} state_e;

  localparam logic [`OPCODE_COUNT-1:0] ONE_HOT = `OPCODE_COUNT'(1);

  localparam int G_ALU_ONE_OP     = 0;
  localparam int G_ALU_TWO_OP     = 1;
  localparam int G_REGISTER       = 2;
  localparam int G_LOAD_DIRECT    = 3;
  localparam int G_LOAD_INDIRECT  = 4;
  localparam int G_STORE_DIRECT   = 5;
  localparam int G_STORE_INDIRECT = 6;
  localparam int G_LOAD           = 7;
  localparam int G_STORE          = 8;
  localparam int G_MEMORY         = 9;
  localparam int G_ALU            = 10;

  state_e state, state_next;

  type_e                   dec_idx;
  logic [`OPCODE_COUNT-1:0] dec_type;
  logic [R_ADDR_WIDTH-1:0] dec_rd, dec_rr;
  logic [IMD_WIDTH-1:0]    dec_imd;
  logic                    dec_two;
  logic                    accept;

  logic [`OPCODE_COUNT-1:0] pend_type;
  logic [R_ADDR_WIDTH-1:0] pend_rd, pend_rr;

  function automatic logic [`GROUP_COUNT-1:0] group_of(input logic [`OPCODE_COUNT-1:0] t);
    logic [`GROUP_COUNT-1:0] g;
    g                   = '0;
    g[G_ALU_ONE_OP]     = t[T_NEG];
    g[G_ALU_TWO_OP]     = t[T_ADD] | t[T_ADC] | t[T_SUB] | t[T_AND] | t[T_EOR] | t[T_OR];
    g[G_REGISTER]       = t[T_MOV] | t[T_LDI];
    g[G_LOAD_DIRECT]    = t[T_LDS];
    g[G_LOAD_INDIRECT]  = t[T_LD_Y];
    g[G_STORE_DIRECT]   = t[T_STS];
    g[G_STORE_INDIRECT] = 1'b0;
    g[G_LOAD]           = g[G_LOAD_DIRECT] | g[G_LOAD_INDIRECT];
    g[G_STORE]          = g[G_STORE_DIRECT] | g[G_STORE_INDIRECT];
    g[G_MEMORY]         = g[G_LOAD] | g[G_STORE];
    g[G_ALU]            = g[G_ALU_ONE_OP] | g[G_ALU_TWO_OP];
    return g;
  endfunction

  assign instr_ready = !flush && (!out_valid || out_ready);
  assign accept      = instr_valid && instr_ready;
  assign opcode_bit  = 3'b000;

  // Decode of a first (or only) word; fields unused by a type are left at zero.
  always_comb begin
    dec_idx = T_UNKNOWN;
    dec_rd  = '0;
    dec_rr  = '0;
    dec_imd = '0;
    dec_two = 1'b0;
    casez (instruction[15:0])
      16'b0000_0000_0000_0000: dec_idx = T_NOP;
      16'b0000_11??_????_????: begin dec_idx = T_ADD; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0001_11??_????_????: begin dec_idx = T_ADC; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0001_10??_????_????: begin dec_idx = T_SUB; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0010_00??_????_????: begin dec_idx = T_AND; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0010_01??_????_????: begin dec_idx = T_EOR; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0010_10??_????_????: begin dec_idx = T_OR;  dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b0010_11??_????_????: begin dec_idx = T_MOV; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_rr = R_ADDR_WIDTH'({instruction[9], instruction[3:0]}); end
      16'b1001_010?_????_0001: begin dec_idx = T_NEG; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); end
      16'b1110_????_????_????: begin
        dec_idx = T_LDI;
        dec_rd  = R_ADDR_WIDTH'({1'b1, instruction[7:4]});
        dec_imd = IMD_WIDTH'({instruction[11:8], instruction[3:0]});
      end
      16'b1010_0???_????_????: begin
        dec_idx = T_LDS;
        dec_rd  = R_ADDR_WIDTH'({1'b1, instruction[7:4]});
        dec_imd = IMD_WIDTH'({~instruction[8], instruction[8], instruction[10:9], instruction[3:0]});
      end
      16'b1010_1???_????_????: begin
        dec_idx = T_STS;
        dec_rr  = R_ADDR_WIDTH'({1'b1, instruction[7:4]});
        dec_imd = IMD_WIDTH'({~instruction[8], instruction[8], instruction[10:9], instruction[3:0]});
      end
      16'b1000_000?_????_1000: begin dec_idx = T_LD_Y; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); end
`ifdef DECODE_LONG_INSTR_EN
      16'b1001_000?_????_0000: begin dec_idx = T_LDS; dec_rd = R_ADDR_WIDTH'(instruction[8:4]); dec_two = 1'b1; end
      16'b1001_001?_????_0000: begin dec_idx = T_STS; dec_rr = R_ADDR_WIDTH'(instruction[8:4]); dec_two = 1'b1; end
`endif
      default: dec_idx = T_UNKNOWN;
    endcase
    dec_type = ONE_HOT << dec_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    state_next = dec_two ? WAIT2 : IDLE;
        WAIT2:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A consumed result is dropped unless a new one overwrites it on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      opcode_type  <= ONE_HOT;
      opcode_group <= '0;
      opcode_rd    <= '0;
      opcode_rr    <= '0;
      opcode_imd   <= '0;
      out_words    <= 2'd0;
      pend_type    <= '0;
      pend_rd      <= '0;
      pend_rr      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (state == WAIT2) begin
          out_valid    <= 1'b1;
          opcode_type  <= pend_type;
          opcode_group <= group_of(pend_type);
          opcode_rd    <= pend_rd;
          opcode_rr    <= pend_rr;
          opcode_imd   <= IMD_WIDTH'(instruction);
          out_words    <= 2'd2;
        end else if (dec_two) begin
          pend_type <= dec_type;
          pend_rd   <= dec_rd;
          pend_rr   <= dec_rr;
        end else begin
          out_valid    <= 1'b1;
          opcode_type  <= dec_type;
          opcode_group <= group_of(dec_type);
          opcode_rd    <= dec_rd;
          opcode_rr    <= dec_rr;
          opcode_imd   <= dec_imd;
          out_words    <= 2'd1;
        end
      end
    end
  end

endmodule
